// File: rtl/atconv_layer_mem.sv
// rtl/atconv_layer_mem.sv - ATCONV layer-0/1 memory responder with busy-triggered dump stream
// Optional feature macro: ATCONV_MEM_WRCHK_EN (adds o_wr_err and o_l1_wr_cnt)
module atconv_layer_mem #(
    parameter int DW       = 13,
    parameter int AW       = 12,
    parameter int L0_DEPTH = 4096,
    parameter int L1_DEPTH = 1024
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_csel,
    input  logic          i_cwr,
    input  logic [AW-1:0] i_caddr_wr,
    input  logic [DW-1:0] i_cdata_wr,
    input  logic          i_crd,
    input  logic [AW-1:0] i_caddr_rd,
    output logic [DW-1:0] o_cdata_rd,
    input  logic          i_busy,
`ifdef ATCONV_MEM_WRCHK_EN
    output logic          o_wr_err,
    output logic [10:0]   o_l1_wr_cnt,
`endif
    output logic          o_dump_valid,
    input  logic          i_dump_ready,
    output logic          o_dump_sel,
    output logic [AW-1:0] o_dump_addr,
    output logic [DW-1:0] o_dump_data,
    output logic          o_dump_done
);
    localparam int L1_AW = $clog2(L1_DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_ARMED, S_PREF, S_XFER, S_DONE} state_t;

    logic [DW-1:0] r_l0 [L0_DEPTH];
    logic [DW-1:0] r_l1 [L1_DEPTH];
    state_t        r_state;
    logic          r_busy;

    logic          w_wr_l1_in;
    logic          w_rd_l1_in;
    logic          w_l1_wr;
    logic          w_last_l0;
    logic          w_last_l1;
    logic          w_next_sel;
    logic [AW-1:0] w_next_addr;
    logic [DW-1:0] w_next_data;

    // L1 is power-of-two sized, so in-range means the upper address bits are zero (no aliasing)
    assign w_wr_l1_in = (i_caddr_wr[AW-1:L1_AW] == '0);
    assign w_rd_l1_in = (i_caddr_rd[AW-1:L1_AW] == '0);
    assign w_l1_wr    = i_cwr && i_csel && w_wr_l1_in;

    always_ff @(posedge i_clk) begin
        if (i_cwr && !i_csel) r_l0[i_caddr_wr] <= i_cdata_wr;
        if (w_l1_wr)          r_l1[i_caddr_wr[L1_AW-1:0]] <= i_cdata_wr;
    end

    always_comb begin
        o_cdata_rd = '0;
        if (i_crd) begin
            if (!i_csel)         o_cdata_rd = r_l0[i_caddr_rd];
            else if (w_rd_l1_in) o_cdata_rd = r_l1[i_caddr_rd[L1_AW-1:0]];
        end
    end

    assign w_last_l0   = !o_dump_sel && (o_dump_addr == AW'(L0_DEPTH - 1));
    assign w_last_l1   = o_dump_sel && (o_dump_addr[L1_AW-1:0] == L1_AW'(L1_DEPTH - 1));
    assign w_next_sel  = o_dump_sel | w_last_l0;
    assign w_next_addr = w_last_l0 ? '0 : o_dump_addr + 1'b1;
    // Private dump read port: the next word is fetched in the same edge that accepts the current one
    assign w_next_data = w_next_sel ? r_l1[w_next_addr[L1_AW-1:0]] : r_l0[w_next_addr];

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= S_IDLE;
            r_busy       <= 1'b0;
            o_dump_valid <= 1'b0;
            o_dump_sel   <= 1'b0;
            o_dump_addr  <= '0;
            o_dump_data  <= '0;
            o_dump_done  <= 1'b0;
        end else begin
            r_busy      <= i_busy;
            o_dump_done <= 1'b0;
            case (r_state)
                S_IDLE:  if (r_busy) r_state <= S_ARMED;
                S_ARMED: if (!r_busy) r_state <= S_PREF;
                S_PREF: begin
                    if (r_busy) begin
                        r_state <= S_ARMED;
                    end else begin
                        o_dump_sel   <= 1'b0;
                        o_dump_addr  <= '0;
                        o_dump_data  <= r_l0['0];
                        o_dump_valid <= 1'b1;
                        r_state      <= S_XFER;
                    end
                end
                S_XFER: begin
                    if (r_busy) begin
                        o_dump_valid <= 1'b0;
                        r_state      <= S_ARMED;
                    end else if (i_dump_ready) begin
                        if (w_last_l1) begin
                            o_dump_valid <= 1'b0;
                            o_dump_done  <= 1'b1;
                            r_state      <= S_DONE;
                        end else begin
                            o_dump_sel  <= w_next_sel;
                            o_dump_addr <= w_next_addr;
                            o_dump_data <= w_next_data;
                        end
                    end
                end
                S_DONE:  r_state <= r_busy ? S_ARMED : S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef ATCONV_MEM_WRCHK_EN
    logic r_l0_seen;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_wr_err    <= 1'b0;
            o_l1_wr_cnt <= '0;
            r_l0_seen   <= 1'b0;
        end else if (i_cwr) begin
            if ($isunknown(i_csel)) begin
                o_wr_err <= 1'b1;
            end else if (!i_csel) begin
                r_l0_seen <= 1'b1;
            end else begin
                if (!w_wr_l1_in || !r_l0_seen) o_wr_err <= 1'b1;
                if (w_wr_l1_in && o_l1_wr_cnt != '1) o_l1_wr_cnt <= o_l1_wr_cnt + 1'b1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_atconv_layer_mem.sv
// tb/tb_atconv_layer_mem.sv - self-checking bench for atconv_layer_mem
module tb_atconv_layer_mem;
    localparam int DW = 13;
    localparam int AW = 12;
    localparam int NW = 5120;

    logic          clk = 1'b0;
    logic          reset, csel, cwr, crd, busy, dump_ready;
    logic [AW-1:0] caddr_wr, caddr_rd;
    logic [DW-1:0] cdata_wr;
    logic [DW-1:0] cdata_rd, dump_data;
    logic [AW-1:0] dump_addr;
    logic          dump_valid, dump_sel, dump_done;
`ifdef ATCONV_MEM_WRCHK_EN
    logic          wr_err;
    logic [10:0]   l1_wr_cnt;
`endif

    atconv_layer_mem dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_csel       (csel),
        .i_cwr        (cwr),
        .i_caddr_wr   (caddr_wr),
        .i_cdata_wr   (cdata_wr),
        .i_crd        (crd),
        .i_caddr_rd   (caddr_rd),
        .o_cdata_rd   (cdata_rd),
        .i_busy       (busy),
`ifdef ATCONV_MEM_WRCHK_EN
        .o_wr_err     (wr_err),
        .o_l1_wr_cnt  (l1_wr_cnt),
`endif
        .o_dump_valid (dump_valid),
        .i_dump_ready (dump_ready),
        .o_dump_sel   (dump_sel),
        .o_dump_addr  (dump_addr),
        .o_dump_data  (dump_data),
        .o_dump_done  (dump_done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [DW-1:0] m0 [4096];
    logic [DW-1:0] m1 [1024];

    typedef struct {
        logic          cwr;
        logic          crd;
        logic          csel;
        logic [AW-1:0] waddr;
        logic [DW-1:0] wdata;
        logic [AW-1:0] raddr;
        logic [DW-1:0] exp_rd;
    } vec_t;
    vec_t tv [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_write(input logic w, input logic s, input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (w) begin
            if (!s) m0[a] = d;
            else if (a < 1024) m1[a] = d;
        end
    endtask

    function automatic logic [DW-1:0] model_read(input logic r, input logic s, input logic [AW-1:0] a);
        if (!r) return '0;
        if (!s) return m0[a];
        if (a < 1024) return m1[a];
        return '0;
    endfunction

    function automatic logic [DW-1:0] exp_data(input int k);
        return (k < 4096) ? m0[k] : m1[k - 4096];
    endfunction

    // stop_kind: 0 run to completion, 1 raise busy at L0 stop_addr, 2 reset at L1 stop_addr
    task automatic do_dump(input bit rnd, input int stop_kind, input int stop_addr);
        int k = 0;
        bit prev_stall = 0;
        logic ps;
        logic [AW-1:0] pa;
        logic [DW-1:0] pd;
        busy = 1'b1;
        step();
        step();
        busy = 1'b0;
        step(); #2 chk("lat_edge1", dump_valid, 0);
        step(); #2 chk("lat_edge2", dump_valid, 0);
        step();
        for (int cyc = 0; cyc < 12000; cyc++) begin
            dump_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            #2;
            if (cyc == 0) chk("first_valid", dump_valid, 1);
            if (!dump_valid) begin
                chk("valid_hold", dump_valid, 1);
                return;
            end
            if (prev_stall) begin
                chk("stall_sel", dump_sel, ps);
                chk("stall_addr", dump_addr, pa);
                chk("stall_data", dump_data, pd);
            end
            if (stop_kind == 1 && !dump_sel && dump_addr == AW'(stop_addr)) begin
                dump_ready = 1'b0;
                busy = 1'b1;
                step();
                step(); #2 chk("abort_valid", dump_valid, 0);
                return;
            end
            if (stop_kind == 2 && dump_sel && dump_addr == AW'(stop_addr)) begin
                reset = 1'b1;
                step(); #2;
                chk("rst_valid", dump_valid, 0);
                chk("rst_done", dump_done, 0);
                chk("rst_addr", dump_addr, 0);
                chk("rst_sel", dump_sel, 0);
                reset = 1'b0;
                return;
            end
            chk("dump_sel", dump_sel, (k >= 4096) ? 1 : 0);
            chk("dump_addr", dump_addr, (k >= 4096) ? k - 4096 : k);
            chk("dump_data", dump_data, exp_data(k));
            chk("dump_done_early", dump_done, 0);
            prev_stall = !dump_ready;
            ps = dump_sel; pa = dump_addr; pd = dump_data;
            if (dump_ready) begin
                k++;
                if (k == NW) begin
                    step(); #2;
                    chk("done_pulse", dump_done, 1);
                    chk("done_valid", dump_valid, 0);
                    step(); #2;
                    chk("done_clear", dump_done, 0);
                    step();
                    return;
                end
            end
            step();
        end
        chk("dump_timeout", k, NW);
    endtask

    initial begin
        tv[0]  = '{1'b1, 1'b0, 1'b0, 12'd5,    13'h0123, 12'd5,    13'h0000};
        tv[1]  = '{1'b0, 1'b1, 1'b0, 12'd0,    13'h0000, 12'd5,    13'h0123};
        tv[2]  = '{1'b0, 1'b0, 1'b0, 12'd0,    13'h0000, 12'd5,    13'h0000};
        tv[3]  = '{1'b1, 1'b0, 1'b0, 12'd7,    13'h0AAA, 12'd0,    13'h0000};
        tv[4]  = '{1'b1, 1'b0, 1'b1, 12'd7,    13'h1555, 12'd0,    13'h0000};
        tv[5]  = '{1'b1, 1'b1, 1'b1, 12'd0,    13'h0000, 12'd7,    13'h1555};
        tv[6]  = '{1'b0, 1'b1, 1'b0, 12'd0,    13'h0000, 12'd7,    13'h0AAA};
        tv[7]  = '{1'b1, 1'b1, 1'b1, 12'd1024, 13'h1FFF, 12'd0,    13'h0000};
        tv[8]  = '{1'b0, 1'b1, 1'b1, 12'd0,    13'h0000, 12'd0,    13'h0000};
        tv[9]  = '{1'b0, 1'b1, 1'b1, 12'd0,    13'h0000, 12'd1024, 13'h0000};
        tv[10] = '{1'b1, 1'b0, 1'b0, 12'd9,    13'h0001, 12'd0,    13'h0000};
        tv[11] = '{1'b1, 1'b1, 1'b0, 12'd9,    13'h0002, 12'd9,    13'h0001};
        tv[12] = '{1'b0, 1'b1, 1'b0, 12'd0,    13'h0000, 12'd9,    13'h0002};
        tv[13] = '{1'b0, 1'b1, 1'b1, 12'd0,    13'h0000, 12'd7,    13'h1555};

        reset = 1'b1; csel = 1'b0; cwr = 1'b0; crd = 1'b0; busy = 1'b0; dump_ready = 1'b0;
        caddr_wr = '0; caddr_rd = '0; cdata_wr = '0;
        step(); step();
        reset = 1'b0;
        #2;
        chk("reset_valid", dump_valid, 0);
        chk("reset_done", dump_done, 0);
        chk("reset_sel", dump_sel, 0);
        chk("reset_addr", dump_addr, 0);
        chk("reset_data", dump_data, 0);
        step();

        for (int i = 0; i < NW; i++) begin
            cwr = 1'b1;
            csel = (i >= 4096);
            caddr_wr = AW'((i >= 4096) ? i - 4096 : i);
            cdata_wr = DW'($urandom);
            model_write(cwr, csel, caddr_wr, cdata_wr);
            step();
        end
        cwr = 1'b0;

        for (int i = 0; i < 14; i++) begin
            cwr = tv[i].cwr; crd = tv[i].crd; csel = tv[i].csel;
            caddr_wr = tv[i].waddr; cdata_wr = tv[i].wdata; caddr_rd = tv[i].raddr;
            #2 chk($sformatf("table_rd[%0d]", i), cdata_rd, tv[i].exp_rd);
            model_write(cwr, csel, caddr_wr, cdata_wr);
            step();
        end
`ifdef ATCONV_MEM_WRCHK_EN
        #2 chk("wr_err_oob", wr_err, 1);
`endif

        for (int i = 0; i < 400; i++) begin
            cwr = 1'($urandom_range(0, 1));
            crd = 1'($urandom_range(0, 1));
            csel = 1'($urandom_range(0, 1));
            caddr_wr = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 1023));
            caddr_rd = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 1023));
            if ($urandom_range(0, 3) == 0) caddr_rd = caddr_wr;
            cdata_wr = DW'($urandom);
            #2 chk("rand_rd", cdata_rd, model_read(crd, csel, caddr_rd));
            model_write(cwr, csel, caddr_wr, cdata_wr);
            step();
        end
        cwr = 1'b0; crd = 1'b0;

        do_dump(1'b0, 0, 0);
        do_dump(1'b1, 1, 2000);
        do_dump(1'b1, 0, 0);
        do_dump(1'b0, 2, 300);
`ifdef ATCONV_MEM_WRCHK_EN
        #2 chk("wr_err_reset", wr_err, 0);
`endif

        for (int i = 0; i < 5; i++) begin
            step(); #2 chk("idle_no_dump", dump_valid, 0);
        end
        for (int i = 0; i < 128; i++) begin
            crd = 1'b1;
            csel = i[0];
            caddr_rd = i[0] ? AW'($urandom_range(0, 1023)) : AW'($urandom_range(0, 4095));
            #2 chk("post_reset_rd", cdata_rd, model_read(crd, csel, caddr_rd));
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
